// File: rtl/testbench_top_pkg.sv
// Timer block shared definitions: register addresses,
// control/status bit positions and prescaler helpers.
package testbench_top_pkg;

   localparam logic [7:0] ADDR_TDR  = 8'h00;
   localparam logic [7:0] ADDR_TCR  = 8'h01;
   localparam logic [7:0] ADDR_TSR  = 8'h02;
   localparam logic [7:0] ADDR_TCNT = 8'h03;

   localparam int TCR_LOAD = 7;
   localparam int TCR_DOWN = 5;
   localparam int TCR_EN   = 4;
   localparam int TCR_CKS1 = 1;
   localparam int TCR_CKS0 = 0;

   localparam int TSR_UDF = 1;
   localparam int TSR_OVF = 0;

   // Implemented TCR bits; reserved bits always read 0
   localparam logic [7:0] TCR_MASK = 8'hB3;

   typedef enum logic [1:0] {
      CKS_DIV2  = 2'd0,
      CKS_DIV4  = 2'd1,
      CKS_DIV8  = 2'd2,
      CKS_DIV16 = 2'd3
   } cks_e;

   // Low prescaler bits that must all be 1 for a tick
   function automatic logic [3:0] cks_mask(input cks_e c);
      return 4'((5'd2 << c) - 5'd1);
   endfunction

endpackage

// File: rtl/testbench_top_if.sv
// APB-style register bus between CPU model and timer.
// master drives select/enable/addr/wdata; slave returns rdata/ready/err.
interface testbench_top_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/testbench_top_timer_prescaler.sv
// Clock divider producing a one-cycle tick every 2/4/8/16 pclk.
// Ports: pclk, presetn, run (count enable), cks (divide select), tick.
module timer_prescaler
   import testbench_top_pkg::*;
(
   input  logic pclk,
   input  logic presetn,
   input  logic run,
   input  cks_e cks,
   output logic tick
);

   logic [3:0] cnt;
   logic [3:0] mask;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)
         cnt <= 4'd0;
      else if (!run)
         cnt <= 4'd0;
      else
         cnt <= cnt + 4'd1;
   end

   // Periods divide 16, so masking the free-running count suffices
   assign mask = cks_mask(cks);
   assign tick = run && ((cnt & mask) == mask);

endmodule

// File: rtl/testbench_top.sv
// 8-bit up/down timer with TDR/TCR/TSR/TCNT registers on an APB slave.
// Ports: pclk, presetn, bus (APB slave), tmr_ovf, tmr_udf (sticky flags).
module testbench_top
   import testbench_top_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic            pclk,
   input  logic            presetn,
   testbench_top_if.slave  bus,
   output logic            tmr_ovf,
   output logic            tmr_udf
);

   logic [DATA_W-1:0] tdr;
   logic [DATA_W-1:0] tcr;
   logic [1:0]        tsr;
   logic [DATA_W-1:0] tcnt;

   logic [DATA_W-1:0] tcnt_nxt;
   logic [1:0]        tsr_nxt;

   logic acc, wr, rd;
   logic sel_tdr, sel_tcr, sel_tsr, sel_tcnt, mapped;
   logic load, down, en, run, tick;
   logic udf_set, ovf_set;

   assign acc = bus.psel & bus.penable;
   assign wr  = acc & bus.pwrite;
   assign rd  = acc & ~bus.pwrite;

   assign sel_tdr  = bus.paddr == ADDR_W'(ADDR_TDR);
   assign sel_tcr  = bus.paddr == ADDR_W'(ADDR_TCR);
   assign sel_tsr  = bus.paddr == ADDR_W'(ADDR_TSR);
   assign sel_tcnt = bus.paddr == ADDR_W'(ADDR_TCNT);
   assign mapped   = sel_tdr | sel_tcr | sel_tsr | sel_tcnt;

   assign load = tcr[TCR_LOAD];
   assign down = tcr[TCR_DOWN];
   assign en   = tcr[TCR_EN];
   assign run  = en & ~load;

   timer_prescaler u_presc (
      .pclk    (pclk),
      .presetn (presetn),
      .run     (run),
      .cks     (cks_e'(tcr[TCR_CKS1:TCR_CKS0])),
      .tick    (tick)
   );

   always_comb begin
      tcnt_nxt = tcnt;
      udf_set  = 1'b0;
      ovf_set  = 1'b0;
      if (load) begin
         tcnt_nxt = tdr;
      end else if (tick) begin
         if (down) begin
            tcnt_nxt = tcnt - DATA_W'(1);
            udf_set  = tcnt == '0;
         end else begin
            tcnt_nxt = tcnt + DATA_W'(1);
            ovf_set  = tcnt == '1;
         end
      end
   end

   // Software write-0-to-clear first, then hardware set on top
   always_comb begin
      tsr_nxt = tsr;
      if (wr && sel_tsr)
         tsr_nxt = tsr & bus.pwdata[1:0];
      tsr_nxt[TSR_UDF] = tsr_nxt[TSR_UDF] | udf_set;
      tsr_nxt[TSR_OVF] = tsr_nxt[TSR_OVF] | ovf_set;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tdr  <= '0;
         tcr  <= '0;
         tsr  <= '0;
         tcnt <= '0;
      end else begin
         if (wr && sel_tdr)
            tdr <= bus.pwdata;
         if (wr && sel_tcr)
            tcr <= bus.pwdata & DATA_W'(TCR_MASK);
         tsr  <= tsr_nxt;
         tcnt <= tcnt_nxt;
      end
   end

   always_comb begin
      bus.prdata = '0;
      if (rd) begin
         unique case (1'b1)
            sel_tdr:  bus.prdata = tdr;
            sel_tcr:  bus.prdata = tcr;
            sel_tsr:  bus.prdata = DATA_W'(tsr);
            sel_tcnt: bus.prdata = tcnt;
            default:  bus.prdata = '0;
         endcase
      end
   end

   assign bus.pready  = 1'b1;
   assign bus.pslverr = acc & ~mapped;

   assign tmr_ovf = tsr[TSR_OVF];
   assign tmr_udf = tsr[TSR_UDF];

endmodule

// File: tb/tb_testbench_top.sv
// Self-checking bench for the APB timer: directed scenarios plus
// randomized register traffic against a cycle-level behavioural model.
module tb_testbench_top;

   logic pclk = 1'b0;
   logic presetn = 1'b0;
   logic tmr_ovf;
   logic tmr_udf;

   testbench_top_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   testbench_top #(.ADDR_W(8), .DATA_W(8)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus),
      .tmr_ovf (tmr_ovf),
      .tmr_udf (tmr_udf)
   );

   always #5 pclk = ~pclk;

   int tests = 0;
   int fails = 0;

   // Behavioural model state
   logic [7:0] m_tdr, m_tcr, m_cnt;
   logic [1:0] m_tsr;
   int         m_run;

   task automatic model_reset();
      m_tdr = 8'h00;
      m_tcr = 8'h00;
      m_cnt = 8'h00;
      m_tsr = 2'b00;
      m_run = 0;
   endtask

   function automatic logic [7:0] exp_rd(input logic [7:0] a);
      case (a)
         8'h00:   return m_tdr;
         8'h01:   return m_tcr;
         8'h02:   return {6'b0, m_tsr};
         8'h03:   return m_cnt;
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One pclk: model advances using the bus values being driven now
   task automatic step();
      logic load, down, en, tick;
      int   per;
      logic udf, ovf;
      load = m_tcr[7];
      down = m_tcr[5];
      en   = m_tcr[4];
      per  = 2 << m_tcr[1:0];
      tick = en && !load && ((m_run % per) == per - 1);
      udf  = tick && down && (m_cnt == 8'h00);
      ovf  = tick && !down && (m_cnt == 8'hFF);
      if (load)
         m_cnt = m_tdr;
      else if (tick)
         m_cnt = down ? m_cnt - 8'd1 : m_cnt + 8'd1;
      m_run = (en && !load) ? m_run + 1 : 0;
      if (bus.psel && bus.penable && bus.pwrite) begin
         case (bus.paddr)
            8'h00:   m_tdr = bus.pwdata;
            8'h01:   m_tcr = bus.pwdata & 8'hB3;
            8'h02:   m_tsr = m_tsr & bus.pwdata[1:0];
            default: ;
         endcase
      end
      m_tsr = m_tsr | {udf, ovf};
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      repeat (n) step();
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b1;
      bus.paddr   = a;
      bus.pwdata  = d;
      step();
      bus.penable = 1'b1;
      #1;
      chk("wr_err", {7'b0, bus.pslverr}, {7'b0, a > 8'h03});
      step();
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input string tag);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = a;
      step();
      bus.penable = 1'b1;
      #1;
      chk(tag, bus.prdata, exp_rd(a));
      chk({tag, "_err"}, {7'b0, bus.pslverr}, {7'b0, a > 8'h03});
      step();
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_ovf"}, {7'b0, tmr_ovf}, {7'b0, m_tsr[0]});
      chk({tag, "_udf"}, {7'b0, tmr_udf}, {7'b0, m_tsr[1]});
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] a;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = 8'h00;
      bus.pwdata  = 8'h00;
      model_reset();

      // Reset defaults
      repeat (3) @(posedge pclk);
      #1;
      presetn = 1'b1;
      chk("rst_ovf", {7'b0, tmr_ovf}, 8'h00);
      chk("rst_udf", {7'b0, tmr_udf}, 8'h00);
      chk("rst_prdata", bus.prdata, 8'h00);
      for (int i = 0; i < 4; i++) begin
         a = 8'(i);
         rd(a, "rst_reg");
         chk("rst_const", exp_rd(a), 8'h00);
      end

      // Countdown underflow at clk/2 from 0x63
      wr(8'h00, 8'h63);
      wr(8'h01, 8'h80);
      wr(8'h01, 8'h30);
      idle(146);
      chk("idle_prdata", bus.prdata, 8'h00);
      rd(8'h02, "udf_early");
      chk("udf_early_c", exp_rd(8'h02), 8'h00);
      idle(60);
      rd(8'h02, "udf_late");
      chk("udf_late_c", exp_rd(8'h02), 8'h02);
      chk_flags("udf");
      chk("udf_pin", {7'b0, tmr_udf}, 8'h01);

      // Mid-count reload with random W
      wr(8'h02, 8'h00);
      w = 8'($urandom_range(26, 200));
      wr(8'h00, w);
      wr(8'h01, 8'h80);
      wr(8'h01, 8'h30);
      idle(46);
      rd(8'h02, "reload_early");
      chk("reload_early_c", exp_rd(8'h02), 8'h00);
      idle(2 * (int'(w) + 1));
      rd(8'h02, "reload_late");
      chk("reload_late_c", exp_rd(8'h02), 8'h02);

      // Short reload 0x10
      wr(8'h02, 8'h00);
      wr(8'h00, 8'h10);
      wr(8'h01, 8'h80);
      wr(8'h01, 8'h30);
      idle(28);
      rd(8'h02, "short_early");
      idle(10);
      rd(8'h02, "short_late");
      chk("short_late_c", exp_rd(8'h02), 8'h02);

      // Flag clear semantics
      wr(8'h02, 8'hFF);
      rd(8'h02, "w1_keep");
      chk("w1_keep_c", exp_rd(8'h02), 8'h02);
      wr(8'h02, 8'h00);
      rd(8'h02, "w0_clr");
      chk("w0_clr_c", exp_rd(8'h02), 8'h00);
      chk_flags("clr");

      // Count-up overflow at clk/4 from 0xF0
      wr(8'h00, 8'hF0);
      wr(8'h01, 8'h80);
      wr(8'h01, 8'h11);
      idle(55);
      rd(8'h02, "ovf_early");
      chk("ovf_early_c", exp_rd(8'h02), 8'h00);
      idle(12);
      rd(8'h02, "ovf_late");
      chk("ovf_late_c", exp_rd(8'h02), 8'h01);
      chk_flags("ovf");

      // Unmapped addresses
      rd(8'h07, "unmapped_rd");
      wr(8'h80, 8'h5A);
      rd(8'h00, "after_unmapped");

      // Randomized register traffic
      for (int i = 0; i < 150; i++) begin
         a = 8'($urandom_range(0, 4));
         w = 8'($urandom);
         if (a == 8'h01 && w[7] && ($urandom_range(0, 3) != 0))
            w[7] = 1'b0;
         if (a == 8'h00 && w < 8'h08)
            w = 8'hFE;
         wr(a, w);
         idle($urandom_range(0, 24));
         rd(8'($urandom_range(0, 5)), "rnd_rd");
         chk_flags("rnd");
      end

      // Reset mid-count aborts the count
      wr(8'h00, 8'h40);
      wr(8'h01, 8'h80);
      wr(8'h01, 8'h31);
      idle(20);
      presetn = 1'b0;
      #2;
      model_reset();
      chk_flags("rst_mid");
      presetn = 1'b1;
      rd(8'h03, "rst_mid_cnt");
      chk("rst_mid_cnt_c", exp_rd(8'h03), 8'h00);
      rd(8'h01, "rst_mid_tcr");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
